// File: rtl/me2_ldst_resp_q_t_if.sv
// Bus bundle for the ME2 load/store response queue: request, AHB ldst2 data phase,
// writeback response and stall.
interface me2_ldst_resp_q_t_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic             req_valid;
  logic [3:0]       req_memop;
  logic [OFF_W-1:0] req_off;
  logic [TAG_W-1:0] req_tag;
  logic [XLEN-1:0]  req_wdata;
  logic             req_misal;
  logic [XLEN-1:0]  ldst2_ahb_HRDATA;
  logic             ldst2_ahb_HREADY;
  logic             ldst2_ahb_HRESP;
  logic [XLEN-1:0]  ldst2_ahb_HWDATA;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_load;
  logic             rsp_err;
  logic             s_me2_memhaz_D;

  modport master (
    output req_valid, req_memop, req_off, req_tag, req_wdata,
           ldst2_ahb_HRDATA, ldst2_ahb_HREADY, ldst2_ahb_HRESP, rsp_ready,
    input  req_misal, ldst2_ahb_HWDATA, rsp_valid, rsp_data, rsp_tag,
           rsp_load, rsp_err, s_me2_memhaz_D
  );

  modport slave (
    input  req_valid, req_memop, req_off, req_tag, req_wdata,
           ldst2_ahb_HRDATA, ldst2_ahb_HREADY, ldst2_ahb_HRESP, rsp_ready,
    output req_misal, ldst2_ahb_HWDATA, rsp_valid, rsp_data, rsp_tag,
           rsp_load, rsp_err, s_me2_memhaz_D
  );
endinterface

// File: rtl/me2_ldst_resp_q_t.sv
// ME2 load/store response queue: tracks AHB ldst2 operations from address phase to
// writeback. Optional misalignment trap: define ME2_MISALIGN_CHECK_EN.
module me2_ldst_resp_q_t #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input logic                CLK,
  input logic                RST,
  me2_ldst_resp_q_t_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN/8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int NB    = XLEN/8;

  typedef enum logic [1:0] {ST_FREE, ST_ISSUED, ST_DONE} ent_st_t;

  ent_st_t          st_q[DEPTH],    st_d[DEPTH];
  logic [3:0]       op_q[DEPTH],    op_d[DEPTH];
  logic [OFF_W-1:0] off_q[DEPTH],   off_d[DEPTH];
  logic [TAG_W-1:0] tag_q[DEPTH],   tag_d[DEPTH];
  logic [XLEN-1:0]  wdata_q[DEPTH], wdata_d[DEPTH];
  logic [XLEN-1:0]  data_q[DEPTH],  data_d[DEPTH];
  logic             err_q[DEPTH],   err_d[DEPTH];
  logic             ill_q[DEPTH],   ill_d[DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, dp_ptr, scan_idx;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full, dp_found, head_done, push, pop, complete, misal;

  function automatic logic [1:0] size_lg(input logic [3:0] op);
    case (op)
      4'h1, 4'h9, 4'hA: return 2'd0;
      4'h2, 4'hB, 4'hC: return 2'd1;
      4'h3, 4'hD, 4'hE: return 2'd2;
      default:          return 2'd3;
    endcase
  endfunction

  function automatic logic is_ill(input logic [3:0] op);
    if (op inside {[4'h5:4'h8]}) return 1'b1;
    return (XLEN == 32) && (op == 4'h4 || op == 4'hE || op == 4'hF);
  endfunction

  function automatic logic [XLEN-1:0] fmt_load(input logic [3:0] op,
                                               input logic [OFF_W-1:0] off,
                                               input logic [XLEN-1:0] rd);
    logic [XLEN-1:0] sh, mask;
    int unsigned     w;
    logic            sgn;
    sh = rd >> (8 * off);
    w  = 32'd8 << size_lg(op);
    if (w >= XLEN) return sh;
    mask = '1;
    mask = mask >> (XLEN - w);
    sgn  = (op == 4'h9 || op == 4'hB || op == 4'hD) && sh[w-1];
    return (sh & mask) | (sgn ? ~mask : '0);
  endfunction

  function automatic logic [XLEN-1:0] lane_rep(input logic [3:0] op, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] r;
    int unsigned     m;
    m = ((32'd1 << size_lg(op)) - 32'd1) & (NB - 1);
    r = '0;
    for (int unsigned i = 0; i < NB; i++) r[8*i +: 8] = wd[8*(i & m) +: 8];
    return r;
  endfunction

`ifdef ME2_MISALIGN_CHECK_EN
  assign misal = bus.req_valid && (bus.req_memop != 4'h0) &&
                 ((4'(bus.req_off) & ((4'd1 << size_lg(bus.req_memop)) - 4'd1)) != 4'h0);
`else
  assign misal = 1'b0;
`endif

  // Data-phase owner is the oldest ISSUED entry; trapped entries are skipped.
  always_comb begin
    dp_found = 1'b0;
    dp_ptr   = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = rd_q + PTR_W'(i);
      if (!dp_found && st_q[scan_idx] == ST_ISSUED) begin
        dp_found = 1'b1;
        dp_ptr   = scan_idx;
      end
    end
  end

  assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign head_done = (st_q[rd_q] == ST_DONE);
  assign push      = bus.req_valid && (bus.req_memop != 4'h0) && bus.ldst2_ahb_HREADY && !full;
  assign pop       = head_done && bus.rsp_ready;
  assign complete  = dp_found && bus.ldst2_ahb_HREADY;

  always_comb begin
    st_d = st_q; op_d = op_q; off_d = off_q; tag_d = tag_q;
    wdata_d = wdata_q; data_d = data_q; err_d = err_q; ill_d = ill_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    if (complete) begin
      st_d[dp_ptr]   = ST_DONE;
      err_d[dp_ptr]  = bus.ldst2_ahb_HRESP || ill_q[dp_ptr];
      data_d[dp_ptr] = (op_q[dp_ptr][3] && !bus.ldst2_ahb_HRESP && !ill_q[dp_ptr]) ?
                       fmt_load(op_q[dp_ptr], off_q[dp_ptr], bus.ldst2_ahb_HRDATA) : '0;
    end
    if (pop) begin
      st_d[rd_q] = ST_FREE;
      rd_d       = rd_q + 1'b1;
    end
    if (push) begin
      st_d[wr_q]    = misal ? ST_DONE : ST_ISSUED;
      op_d[wr_q]    = bus.req_memop;
      off_d[wr_q]   = bus.req_off;
      tag_d[wr_q]   = bus.req_tag;
      wdata_d[wr_q] = bus.req_wdata;
      data_d[wr_q]  = '0;
      err_d[wr_q]   = misal;
      ill_d[wr_q]   = is_ill(bus.req_memop);
      wr_d          = wr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i] <= ST_FREE; op_q[i] <= '0; off_q[i] <= '0; tag_q[i] <= '0;
        wdata_q[i] <= '0; data_q[i] <= '0; err_q[i] <= 1'b0; ill_q[i] <= 1'b0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d; op_q <= op_d; off_q <= off_d; tag_q <= tag_d;
      wdata_q <= wdata_d; data_q <= data_d; err_q <= err_d; ill_q <= ill_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.req_misal        = misal;
  assign bus.ldst2_ahb_HWDATA = dp_found ? lane_rep(op_q[dp_ptr], wdata_q[dp_ptr]) : '0;
  assign bus.rsp_valid        = head_done;
  assign bus.rsp_data         = data_q[rd_q];
  assign bus.rsp_tag          = tag_q[rd_q];
  assign bus.rsp_load         = op_q[rd_q][3];
  assign bus.rsp_err          = err_q[rd_q];
  assign bus.s_me2_memhaz_D   = full || (dp_found && !bus.ldst2_ahb_HREADY);
endmodule

// File: doc/me2_ldst_resp_q_t.md
# me2_ldst_resp_q_t

Parametrised memory-stage load/store response queue for the ME2 pipeline stage. It sits between the AHB load/store master port (ldst2) and writeback. The block:
- tracks up to DEPTH accepted memory operations from AHB address phase to writeback;
- captures and formats HRDATA (lane shift, sign/zero extension) and drives HWDATA;
- reports bus errors per operation;
- stalls the pipeline when full or when a data phase is waited.

## Interface
Parameters:
- XLEN, 32: data width; 32 or 64.
- DEPTH, 4: queue entries; power of two, 2..8.
- TAG_W, 5: writeback tag width (destination register index).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- req_valid  in  1  operation presented in AHB address phase this cycle.
- req_memop  in  4  operation code: 0 none, 1 SB, 2 SH, 3 SW, 4 SD, 9 LB, A LBU, B LH, C LHU, D LW, E LWU, F LD.
- req_off  in  log2(XLEN/8)  byte offset (ALU address low bits).
- req_tag  in  TAG_W  writeback tag.
- req_wdata  in  XLEN  store data, right-aligned.
- req_misal  out  XLEN==64?1:1  combinational misalignment flag for the presented request (tie 0 when check compiled out).
- ldst2_ahb_HRDATA  in  XLEN  read data.
- ldst2_ahb_HREADY  in  1  transfer ready.
- ldst2_ahb_HRESP  in  1  error response.
- ldst2_ahb_HWDATA  out  XLEN  write data for current data phase.
- rsp_valid  out  1  head entry completed, result available.
- rsp_ready  in  1  writeback accepts result.
- rsp_data  out  XLEN  formatted load result (0 for stores/errors).
- rsp_tag  out  TAG_W  tag of head entry.
- rsp_load  out  1  head entry is a load (writes register).
- rsp_err  out  1  head entry ended in bus error or misalignment.
- s_me2_memhaz_D  out  1  pipeline stall request.

## Operation
- Push: req_valid && req_memop!=0 && HREADY && !full → write entry at wr_ptr (memop, off, tag, wdata), state ISSUED; wr_ptr++.
- memop 4, E, F with XLEN=32: entry marked illegal; it completes as an error.
- Data phase owner: oldest ISSUED entry (dp_ptr). HWDATA = dp entry wdata replicated across lanes by size (byte ×XLEN/8, half ×XLEN/16, ...); 0 when no ISSUED entry.
- Completion: HREADY=1 with dp entry ISSUED:
  - HRESP=0 → load data = HRDATA >> (8·off), then extended per memop (LB/LH/LW sign; LBU/LHU/LWU zero; LD none); store data = 0; state DONE, err=0; dp_ptr++.
  - HRESP=1 → state DONE, err=1, data 0.
  - The first AHB error cycle (HRESP=1, HREADY=0) takes no action.
- Pop: rsp_valid && rsp_ready → rd_ptr++, entry invalid. rsp_* are the head entry registers; rsp_valid = head DONE.
- Stall: s_me2_memhaz_D = full || (dp entry ISSUED && !HREADY).
- Push is blocked when full, even with a simultaneous pop; the freed slot is usable next cycle.
- Push and completion of a different entry in the same cycle are both performed.

## Timing
- Reset: all entries invalid; all pointers 0; count 0. Outputs: rsp_valid 0, rsp_data 0, rsp_tag 0, rsp_load 0, rsp_err 0, HWDATA 0, s_me2_memhaz_D 0, req_misal 0.
- Latency:
  - push at edge N → entry is data-phase owner in cycle N+1;
  - completion at edge M → rsp_valid high in cycle M+1;
  - minimum push-to-result is 2 cycles.
- rsp_* are held stable while rsp_valid && !rsp_ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = count==DEPTH; empty = count==0.
- Reset asserted mid-operation discards all entries immediately (asynchronous); no result is emitted for them.

## Configuration
- ME2_MISALIGN_CHECK_EN defined:
  - req_misal = 1 when req_off is not a multiple of the access size. Upstream suppresses HTRANS for that request.
  - The entry is pushed as DONE with err=1 and never owns a data phase; dp_ptr skips it.
  - Results stay in order.
- ME2_MISALIGN_CHECK_EN not defined:
  - req_misal tied 0;
  - misaligned accesses are issued and formatted using the shift only (bytes beyond the lane top read as 0).

## Test plan
- XLEN=32: push LB off=3, HRDATA=0x80112233, HREADY=1 next cycle → rsp_data=0xFFFFFF80, rsp_load=1, rsp_err=0, exactly 2 cycles after push.
- Push SH off=2 wdata=0x0000ABCD → HWDATA=0xABCDABCD during data phase; rsp_load=0, rsp_data=0.
- HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on LW → stall high in first cycle; rsp_err=1, rsp_data=0.
- DEPTH=4, rsp_ready=0, four LW completions → s_me2_memhaz_D=1. Fifth push is ignored. Drain four results in push order with matching tags; pointers wrap cleanly.
- Assert RST with 3 entries pending → all outputs 0 immediately; the next push behaves as from reset.
- With ME2_MISALIGN_CHECK_EN: LW off=1 → req_misal=1, rsp_err=1 next cycle, no HREADY consumed. The following aligned LW still completes.
